// File: rtl/alu_load_ctrl_if.sv
// alu_load_ctrl_if: board-side buttons/switches in, ALU operand/opcode registers and status out.
// Rev 1.0
`default_nettype none

interface alu_load_ctrl_if #(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
);
  logic [2:0]        pulsador;
  logic [NBITS-1:0]  entrada;
  logic [NBITS-1:0]  operando_A;
  logic [NBITS-1:0]  operando_B;
  logic [COD_OP-1:0] cod_operacion;
  logic              valid;
  logic              upd;
  logic              err;
  logic [1:0]        state;

  modport master (
    output pulsador, entrada,
    input  operando_A, operando_B, cod_operacion, valid, upd, err, state
  );

  modport slave (
    input  pulsador, entrada,
    output operando_A, operando_B, cod_operacion, valid, upd, err, state
  );
endinterface

`default_nettype wire

// File: rtl/alu_load_ctrl.sv
// alu_load_ctrl: conditions three push-buttons and loads A, B, opcode in order for the ALU.
// Rev 1.0
`default_nettype none

module alu_load_ctrl #(
  parameter int NBITS     = 8,
  parameter int COD_OP    = 6,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_load_ctrl_if.slave  bus
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  logic [2:0]    sync1, sync2, deb, deb_d, press;
  logic [CW-1:0] cnt [3];
  logic [2:0]    sel;

  state_t            state;
  logic [NBITS-1:0]  op_a, op_b;
  logic [COD_OP-1:0] op_code;
  logic              upd, err;

  // Button conditioning: sync, debounce, then a registered rising-edge pulse of the debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.pulsador;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest index wins when several presses land in the same cycle.
  always_comb begin
    sel    = '0;
    sel[0] = press[0];
    sel[1] = press[1] & ~press[0];
    sel[2] = press[2] & ~(|press[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_A;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      upd <= 1'b0;
      err <= 1'b0;
      case (state)
        S_A: begin
          if (sel[0]) begin
            op_a  <= bus.entrada;
            state <= S_B;
          end else if (sel[1] | sel[2]) begin
            err <= 1'b1;
          end
        end
        S_B: begin
          if (sel[0]) begin
            op_a <= bus.entrada;
          end else if (sel[1]) begin
            op_b  <= bus.entrada;
            state <= S_OP;
          end else if (sel[2]) begin
            err <= 1'b1;
          end
        end
        S_OP: begin
          if (sel[0]) begin
            op_a  <= bus.entrada;
            state <= S_B;
          end else if (sel[1]) begin
            op_b <= bus.entrada;
          end else if (sel[2]) begin
            op_code <= bus.entrada[COD_OP-1:0];
            state   <= S_RUN;
            upd     <= 1'b1;
          end
        end
        default: begin
          if (sel[0]) op_a <= bus.entrada;
          if (sel[1]) op_b <= bus.entrada;
          if (sel[2]) op_code <= bus.entrada[COD_OP-1:0];
          upd <= |sel;
        end
      endcase
    end
  end

  assign bus.operando_A    = op_a;
  assign bus.operando_B    = op_b;
  assign bus.cod_operacion = op_code;
  assign bus.valid         = (state == S_RUN);
  assign bus.upd           = upd;
  assign bus.err           = err;
  assign bus.state         = state;

endmodule

`default_nettype wire
